hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. Reads ID-stage source
//  registers and the ID/EX, EX/MEM and MEM/WB control/destination fields.
//  Drives the PC and IF/ID enables, the IF/ID flush and the ID/EX bubble
//  (load-use stall, taken-branch flush), plus the EX-stage operand
//  forwarding selects. It is the consumer end of the ID/EX pipeline register.
// PARAMETERS
//  STALL_CYCLES  1   load-use stall length in cycles (1..7)
//  CNT_W         32  width of perf counters (HAZARD_PERF_EN only)
// PORTS
//  clk          in   1  core clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  id_rs        in   5  ID-stage source register A
//  id_rt        in   5  ID-stage source register B
//  id_uses_rt   in   1  ID instruction reads rt (R-type/store/branch)
//  ex_rs        in   5  EX-stage source A (from ID/EX register)
//  ex_rt        in   5  EX-stage source B (from ID/EX register)
//  ex_AW        in   5  EX-stage destination register
//  ex_regwrite  in   1  EX-stage writes register file
//  ex_memtoreg  in   1  EX-stage is a load
//  ex_pcsrc     in   1  EX-stage branch/jump taken
//  mem_AW       in   5  MEM-stage destination register
//  mem_regwrite in   1  MEM-stage writes register file
//  wb_AW        in   5  WB-stage destination register
//  wb_regwrite  in   1  WB-stage writes register file
//  pc_en        out  1  1 = PC may update
//  ifid_en      out  1  1 = IF/ID register may load
//  ifid_flush   out  1  1 = IF/ID loads a NOP
//  idex_bubble  out  1  1 = ID/EX loads zeroed control (NOP)
//  fwd_a        out  2  ALU A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b        out  2  ALU B select: same encoding
// BEHAVIOUR
//  - Asynchronous reset: state=IDLE, cnt=0. Outputs while rst_n=0 are
//    pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1, fwd_a=fwd_b=00.
//  - Register 0 never matches. No hazard or forward is raised on AW/rs/rt=0.
//  - lu_hit = ex_memtoreg & ex_regwrite & ex_AW!=0 &
//    (ex_AW==id_rs | (id_uses_rt & ex_AW==id_rt)).
//  - FSM states are IDLE, STALL and FLUSH. Control outputs are combinational
//    from state and inputs, so they take effect in the same cycle.
//  - IDLE, ex_pcsrc=1: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1.
//    Next state is FLUSH. ex_pcsrc has priority over lu_hit.
//  - IDLE, lu_hit=1, ex_pcsrc=0: pc_en=0, ifid_en=0, idex_bubble=1.
//    If STALL_CYCLES=1, stay in IDLE. Otherwise cnt<=STALL_CYCLES-1 and
//    next state is STALL.
//  - IDLE, no event: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
//  - STALL: pc_en=0, ifid_en=0, idex_bubble=1, cnt decrements each cycle.
//    Return to IDLE when cnt reaches 1. If ex_pcsrc=1 arrives in STALL,
//    abort the stall and apply the flush outputs instead; next state FLUSH.
//  - FLUSH: lasts exactly one cycle with normal (IDLE, no event) outputs,
//    then IDLE. In this cycle lu_hit and ex_pcsrc are ignored, because the
//    EX stage holds a bubble.
//  - Forwarding is purely combinational and independent of the FSM.
//    fwd_a=10 if mem_regwrite & mem_AW!=0 & mem_AW==ex_rs.
//    Else fwd_a=01 if wb_regwrite & wb_AW!=0 & wb_AW==ex_rs. Else 00.
//    fwd_b uses ex_rt. EX/MEM wins when MEM and WB both match.
//  - Reset asserted mid-stall or mid-flush returns to IDLE immediately.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cnt[CNT_W-1:0] and
//  flush_cnt[CNT_W-1:0]. Both reset to 0. stall_cnt +1 per cycle with
//  pc_en=0 (rst_n=1). flush_cnt +1 per cycle with ifid_flush=1.
//  Both saturate at all-ones and do not wrap.
//  HAZARD_PERF_EN undefined: these ports and counters are absent and the
//  remaining behaviour is identical.
// TESTING
//  1 Reset: rst_n=0 -> pc_en=0, idex_bubble=1, fwd=00. After release,
//    with no hazard, pc_en=ifid_en=1.
//  2 Load-use: ex_memtoreg=1, ex_regwrite=1, ex_AW=5, id_rs=5 ->
//    one cycle with pc_en=0, ifid_en=0, idex_bubble=1, then normal.
//    Repeat with STALL_CYCLES=3 -> exactly 3 stall cycles.
//  3 No false stall: same as 2 but ex_AW=0, or id_rt=5 with id_uses_rt=0
//    -> pc_en stays 1.
//  4 Branch: ex_pcsrc=1 -> ifid_flush=1, idex_bubble=1, pc_en=1 for one
//    cycle. A lu_hit in the following cycle is ignored. ex_pcsrc together
//    with lu_hit -> flush only.
//  5 Forward: ex_rs=7, mem_AW=7, wb_AW=7, both regwrite=1 -> fwd_a=10.
//    Then mem_regwrite=0 -> fwd_a=01. Then ex_rt=0 -> fwd_b=00.
//  6 Perf (HAZARD_PERF_EN): tests 2+4 -> stall_cnt=1, flush_cnt=1.
//    With CNT_W=2, 5 stalls -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and EX operand forwarding.
// Optional HAZARD_PERF_EN macro adds saturating stall/flush performance counters.
module hazard_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_AW,
  input  logic       ex_regwrite,
  input  logic       ex_memtoreg,
  input  logic       ex_pcsrc,
  input  logic [4:0] mem_AW,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_AW,
  input  logic       wb_regwrite,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // state | meaning
  // IDLE  | normal flow, watching for load-use and taken branches
  // STALL | extra load-use stall cycles (STALL_CYCLES > 1 only)
  // FLUSH | EX holds a bubble after a taken branch; hazards ignored
  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       lu_hit;

  assign lu_hit = ex_memtoreg & ex_regwrite & (ex_AW != 5'd0) &
                  ((ex_AW == id_rs) | (id_uses_rt & (ex_AW == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (state)
      IDLE: begin
        if (ex_pcsrc) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nxt   = FLUSH;
        end else if (lu_hit) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (STALL_CYCLES > 1) begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = STALL;
          end
        end
      end
      STALL: begin
        // a taken branch makes the stalled instruction dead, so flush wins
        if (ex_pcsrc) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_nxt     = 3'd0;
          state_nxt   = FLUSH;
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          cnt_nxt     = cnt - 3'd1;
          if (cnt <= 3'd1) state_nxt = IDLE;
        end
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && mem_AW != 5'd0 && mem_AW == ex_rs)    fwd_a = 2'b10;
    else if (wb_regwrite && wb_AW != 5'd0 && wb_AW == ex_rs)  fwd_a = 2'b01;
    if (mem_regwrite && mem_AW != 5'd0 && mem_AW == ex_rt)    fwd_b = 2'b10;
    else if (wb_regwrite && wb_AW != 5'd0 && wb_AW == ex_rt)  fwd_b = 2'b01;
    if (!rst_n) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != {CNT_W{1'b1}})  stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (STALL_CYCLES=1 and =3) share stimulus.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_AW, mem_AW, wb_AW;
  logic id_uses_rt, ex_regwrite, ex_memtoreg, ex_pcsrc, mem_regwrite, wb_regwrite;
  logic pc_en1, ifid_en1, ifid_flush1, idex_bubble1;
  logic pc_en3, ifid_en3, ifid_flush3, idex_bubble3;
  logic [1:0] fwd_a1, fwd_b1, fwd_a3, fwd_b3;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt1, flush_cnt1;
  logic [1:0]  stall_cnt3, flush_cnt3;
`endif

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_AW(ex_AW), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_pcsrc(ex_pcsrc), .mem_AW(mem_AW),
    .mem_regwrite(mem_regwrite), .wb_AW(wb_AW), .wb_regwrite(wb_regwrite),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .fwd_a(fwd_a1), .fwd_b(fwd_b1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  hazard_unit #(.STALL_CYCLES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_AW(ex_AW), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_pcsrc(ex_pcsrc), .mem_AW(mem_AW),
    .mem_regwrite(mem_regwrite), .wb_AW(wb_AW), .wb_regwrite(wb_regwrite),
    .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3),
    .idex_bubble(idex_bubble3), .fwd_a(fwd_a3), .fwd_b(fwd_b3)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
  );

  // control vectors are {pc_en, ifid_en, ifid_flush, idex_bubble}
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] F = 4'b1111;
  localparam logic [3:0] R = 4'b0001;

  typedef struct {
    string      tag;
    logic [3:0] c1;
    logic [3:0] c3;
    logic [3:0] fw;
    bit         rst;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;
  int s1 = 0, f1 = 0, s3 = 0, f3 = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val({e.tag, "/ctl1"}, {28'd0, pc_en1, ifid_en1, ifid_flush1, idex_bubble1}, {28'd0, e.c1});
      check_val({e.tag, "/ctl3"}, {28'd0, pc_en3, ifid_en3, ifid_flush3, idex_bubble3}, {28'd0, e.c3});
      check_val({e.tag, "/fwd1"}, {28'd0, fwd_a1, fwd_b1}, {28'd0, e.fw});
      check_val({e.tag, "/fwd3"}, {28'd0, fwd_a3, fwd_b3}, {28'd0, e.fw});
      if (e.rst) begin
        s1 = 0; f1 = 0; s3 = 0; f3 = 0;
      end else begin
        s1 += int'(!e.c1[3]);
        f1 += int'(e.c1[1]);
        s3 += int'(!e.c3[3]);
        f3 += int'(e.c3[1]);
      end
    end
  end

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_AW = 0;
    ex_regwrite = 0; ex_memtoreg = 0; ex_pcsrc = 0;
    mem_AW = 0; mem_regwrite = 0; wb_AW = 0; wb_regwrite = 0;
  endtask

  task automatic load_use(input logic [4:0] aw, input logic [4:0] rs);
    ex_memtoreg = 1; ex_regwrite = 1; ex_AW = aw; id_rs = rs;
  endtask

  // inputs are already applied; outputs are sampled on the following negedge
  task automatic step(input string tag, input logic [3:0] c1, input logic [3:0] c3,
                      input logic [3:0] fw, input bit r = 1'b0);
    exp_t e;
    e.tag = tag; e.c1 = c1; e.c3 = c3; e.fw = fw; e.rst = r;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    rst_n = 0;
    ex_rs = 7; mem_AW = 7; mem_regwrite = 1;
    @(posedge clk); #1;
    step("rst", R, R, 4'b0000, 1'b1);
    rst_n = 1; clr_in();
    step("idle", N, N, 4'b0000);

    // reset in the middle of a multi-cycle stall
    load_use(5, 5);
    step("rst_mid_lu", S, S, 4'b0000);
    rst_n = 0; clr_in();
    step("rst_mid", R, R, 4'b0000, 1'b1);
    rst_n = 1;
    step("rst_rel", N, N, 4'b0000);

    // load-use on rs
    load_use(5, 5);
    step("lu0", S, S, 4'b0000);
    clr_in();
    step("lu1", N, S, 4'b0000);
    step("lu2", N, S, 4'b0000);
    step("lu3", N, N, 4'b0000);

    // no false stalls
    load_use(0, 0);
    step("nofs_r0", N, N, 4'b0000);
    load_use(5, 3); id_rt = 5; id_uses_rt = 0;
    step("nofs_rt", N, N, 4'b0000);
    load_use(5, 5); ex_regwrite = 0;
    step("nofs_nowr", N, N, 4'b0000);
    load_use(5, 3); id_rt = 5; id_uses_rt = 1;
    step("lu_rt0", S, S, 4'b0000);
    clr_in();
    step("lu_rt1", N, S, 4'b0000);
    step("lu_rt2", N, S, 4'b0000);
    step("lu_rt3", N, N, 4'b0000);

    // taken branch, then a load-use that must be ignored in the flush cycle
    ex_pcsrc = 1;
    step("br0", F, F, 4'b0000);
    clr_in(); load_use(5, 5);
    step("br_ign", N, N, 4'b0000);
    clr_in();
    step("br_after", N, N, 4'b0000);

    // branch and load-use together
    ex_pcsrc = 1; load_use(9, 9);
    step("br_lu", F, F, 4'b0000);
    clr_in();
    step("br_lu1", N, N, 4'b0000);

    // branch aborts a stall in progress
    load_use(6, 6);
    step("abort0", S, S, 4'b0000);
    clr_in(); ex_pcsrc = 1;
    step("abort1", F, F, 4'b0000);
    clr_in();
    step("abort2", N, N, 4'b0000);
    step("abort3", N, N, 4'b0000);

    // forwarding
    ex_rs = 7; ex_rt = 7; mem_AW = 7; wb_AW = 7; mem_regwrite = 1; wb_regwrite = 1;
    step("fwd_mem", N, N, 4'b1010);
    mem_regwrite = 0;
    step("fwd_wb", N, N, 4'b0101);
    ex_rt = 0;
    step("fwd_rt0", N, N, 4'b0100);
    ex_rs = 0; wb_AW = 0;
    step("fwd_r0", N, N, 4'b0000);
    ex_rs = 7; ex_rt = 3; mem_AW = 7; mem_regwrite = 1; wb_AW = 3;
    step("fwd_mix", N, N, 4'b1001);
    ex_rs = 3; ex_rt = 7; mem_regwrite = 1;
    load_use(4, 4);
    step("fwd_stall", S, S, 4'b0110);
    clr_in();
    step("tail1", N, S, 4'b0000);
    step("tail2", N, S, 4'b0000);
    step("tail3", N, N, 4'b0000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) check_val("sb_drain", 32'(sb.size()), 32'd0);

`ifdef HAZARD_PERF_EN
    check_val("stall_cnt1", stall_cnt1, 32'(s1));
    check_val("flush_cnt1", flush_cnt1, 32'(f1));
    check_val("stall_cnt3_sat", {30'd0, stall_cnt3}, (s3 > 3) ? 32'd3 : 32'(s3));
    check_val("flush_cnt3_sat", {30'd0, flush_cnt3}, (f3 > 3) ? 32'd3 : 32'(f3));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
